// File: rtl/zero_run_decode.sv
`default_nettype none
// zero_run_decode: decodes total_zeros and the run_before sequence of one CAVLC
// residual block, drives the upstream bitstream shifter and emits one run per coefficient.
module zero_run_decode #(
  parameter int CHROMA422_EN = 1,
  parameter int WIN_W        = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [1:0]       Mode,
  input  logic [4:0]       TotalCoeff,
  input  logic [WIN_W-1:0] BitstreamShifted,
  output logic [4:0]       NumShift,
  output logic             ShiftEn,
  output logic             RunValid,
  output logic [3:0]       RunIdx,
  output logic [3:0]       RunBefore,
  output logic             Done,
  output logic             Error
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_TOTAL_ZERO = 3'd1,
    S_ZERO_RUN   = 3'd2,
    S_DONE       = 3'd3,
    S_WAIT       = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [4:0] tc_q, tc_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] zl_q, zl_d;
  logic       done_q, done_d;
  logic       error_q, error_d;

  logic [10:0] win11;
  logic [8:0]  tz_w;   // {match, length, value}
  logic [8:0]  rb_w;   // {match, length, value}
  logic [4:0]  max_in, max_q;

  assign win11 = BitstreamShifted[WIN_W-1 -: 11];

  if (WIN_W > 11) begin : g_unused_win
    logic unused_win;
    assign unused_win = ^BitstreamShifted[WIN_W-12:0];
  end

  function automatic logic [8:0] e(input int len, input int val);
    return {1'b1, 4'(len), 4'(val)};
  endfunction

  function automatic logic [4:0] max_coeff(input logic [1:0] m);
    case (m)
      2'd0:    return 5'd16;
      2'd1:    return 5'd15;
      2'd2:    return 5'd4;
      default: return 5'd8;
    endcase
  endfunction

  // 4x4 luma / AC total_zeros, tzVlcIndex 1..15
  function automatic logic [8:0] tz_luma(input logic [3:0] tc, input logic [8:0] b);
    logic [8:0] r;
    r = '0;
    case (tc)
      4'd1: casez (b)
        9'b1_????????: r = e(1,0);   9'b011_??????: r = e(3,1);
        9'b010_??????: r = e(3,2);   9'b0011_?????: r = e(4,3);
        9'b0010_?????: r = e(4,4);   9'b00011_????: r = e(5,5);
        9'b00010_????: r = e(5,6);   9'b000011_???: r = e(6,7);
        9'b000010_???: r = e(6,8);   9'b0000011_??: r = e(7,9);
        9'b0000010_??: r = e(7,10);  9'b00000011_?: r = e(8,11);
        9'b00000010_?: r = e(8,12);  9'b000000011:  r = e(9,13);
        9'b000000010:  r = e(9,14);  9'b000000001:  r = e(9,15);
        default: ;
      endcase
      4'd2: casez (b)
        9'b111_??????: r = e(3,0);   9'b110_??????: r = e(3,1);
        9'b101_??????: r = e(3,2);   9'b100_??????: r = e(3,3);
        9'b011_??????: r = e(3,4);   9'b0101_?????: r = e(4,5);
        9'b0100_?????: r = e(4,6);   9'b0011_?????: r = e(4,7);
        9'b0010_?????: r = e(4,8);   9'b00011_????: r = e(5,9);
        9'b00010_????: r = e(5,10);  9'b000011_???: r = e(6,11);
        9'b000010_???: r = e(6,12);  9'b000001_???: r = e(6,13);
        9'b000000_???: r = e(6,14);
        default: ;
      endcase
      4'd3: casez (b)
        9'b0101_?????: r = e(4,0);   9'b111_??????: r = e(3,1);
        9'b110_??????: r = e(3,2);   9'b101_??????: r = e(3,3);
        9'b0100_?????: r = e(4,4);   9'b0011_?????: r = e(4,5);
        9'b100_??????: r = e(3,6);   9'b011_??????: r = e(3,7);
        9'b0010_?????: r = e(4,8);   9'b00011_????: r = e(5,9);
        9'b00010_????: r = e(5,10);  9'b000001_???: r = e(6,11);
        9'b00001_????: r = e(5,12);  9'b000000_???: r = e(6,13);
        default: ;
      endcase
      4'd4: casez (b)
        9'b00011_????: r = e(5,0);   9'b111_??????: r = e(3,1);
        9'b0101_?????: r = e(4,2);   9'b0100_?????: r = e(4,3);
        9'b110_??????: r = e(3,4);   9'b101_??????: r = e(3,5);
        9'b100_??????: r = e(3,6);   9'b0011_?????: r = e(4,7);
        9'b011_??????: r = e(3,8);   9'b0010_?????: r = e(4,9);
        9'b00010_????: r = e(5,10);  9'b00001_????: r = e(5,11);
        9'b00000_????: r = e(5,12);
        default: ;
      endcase
      4'd5: casez (b)
        9'b0101_?????: r = e(4,0);   9'b0100_?????: r = e(4,1);
        9'b0011_?????: r = e(4,2);   9'b111_??????: r = e(3,3);
        9'b110_??????: r = e(3,4);   9'b101_??????: r = e(3,5);
        9'b100_??????: r = e(3,6);   9'b011_??????: r = e(3,7);
        9'b0010_?????: r = e(4,8);   9'b00001_????: r = e(5,9);
        9'b0001_?????: r = e(4,10);  9'b00000_????: r = e(5,11);
        default: ;
      endcase
      4'd6: casez (b)
        9'b000001_???: r = e(6,0);   9'b00001_????: r = e(5,1);
        9'b111_??????: r = e(3,2);   9'b110_??????: r = e(3,3);
        9'b101_??????: r = e(3,4);   9'b100_??????: r = e(3,5);
        9'b011_??????: r = e(3,6);   9'b010_??????: r = e(3,7);
        9'b0001_?????: r = e(4,8);   9'b001_??????: r = e(3,9);
        9'b000000_???: r = e(6,10);
        default: ;
      endcase
      4'd7: casez (b)
        9'b000001_???: r = e(6,0);   9'b00001_????: r = e(5,1);
        9'b101_??????: r = e(3,2);   9'b100_??????: r = e(3,3);
        9'b011_??????: r = e(3,4);   9'b11_???????: r = e(2,5);
        9'b010_??????: r = e(3,6);   9'b0001_?????: r = e(4,7);
        9'b001_??????: r = e(3,8);   9'b000000_???: r = e(6,9);
        default: ;
      endcase
      4'd8: casez (b)
        9'b000001_???: r = e(6,0);   9'b0001_?????: r = e(4,1);
        9'b00001_????: r = e(5,2);   9'b011_??????: r = e(3,3);
        9'b11_???????: r = e(2,4);   9'b10_???????: r = e(2,5);
        9'b010_??????: r = e(3,6);   9'b001_??????: r = e(3,7);
        9'b000000_???: r = e(6,8);
        default: ;
      endcase
      4'd9: casez (b)
        9'b000001_???: r = e(6,0);   9'b000000_???: r = e(6,1);
        9'b0001_?????: r = e(4,2);   9'b11_???????: r = e(2,3);
        9'b10_???????: r = e(2,4);   9'b001_??????: r = e(3,5);
        9'b01_???????: r = e(2,6);   9'b00001_????: r = e(5,7);
        default: ;
      endcase
      4'd10: casez (b)
        9'b00001_????: r = e(5,0);   9'b00000_????: r = e(5,1);
        9'b001_??????: r = e(3,2);   9'b11_???????: r = e(2,3);
        9'b10_???????: r = e(2,4);   9'b01_???????: r = e(2,5);
        9'b0001_?????: r = e(4,6);
        default: ;
      endcase
      4'd11: casez (b)
        9'b0000_?????: r = e(4,0);   9'b0001_?????: r = e(4,1);
        9'b001_??????: r = e(3,2);   9'b010_??????: r = e(3,3);
        9'b1_????????: r = e(1,4);   9'b011_??????: r = e(3,5);
        default: ;
      endcase
      4'd12: casez (b)
        9'b0000_?????: r = e(4,0);   9'b0001_?????: r = e(4,1);
        9'b01_???????: r = e(2,2);   9'b1_????????: r = e(1,3);
        9'b001_??????: r = e(3,4);
        default: ;
      endcase
      4'd13: casez (b)
        9'b000_??????: r = e(3,0);   9'b001_??????: r = e(3,1);
        9'b1_????????: r = e(1,2);   9'b01_???????: r = e(2,3);
        default: ;
      endcase
      4'd14: casez (b)
        9'b00_???????: r = e(2,0);   9'b01_???????: r = e(2,1);
        9'b1_????????: r = e(1,2);
        default: ;
      endcase
      4'd15: casez (b)
        9'b0_????????: r = e(1,0);   9'b1_????????: r = e(1,1);
        default: ;
      endcase
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [8:0] tz_c420(input logic [3:0] tc, input logic [2:0] b);
    logic [8:0] r;
    r = '0;
    case (tc)
      4'd1: casez (b)
        3'b1??: r = e(1,0);  3'b01?: r = e(2,1);
        3'b001: r = e(3,2);  3'b000: r = e(3,3);
        default: ;
      endcase
      4'd2: casez (b)
        3'b1??: r = e(1,0);  3'b01?: r = e(2,1);  3'b00?: r = e(2,2);
        default: ;
      endcase
      4'd3: casez (b)
        3'b1??: r = e(1,0);  3'b0??: r = e(1,1);
        default: ;
      endcase
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [8:0] tz_c422(input logic [3:0] tc, input logic [4:0] b);
    logic [8:0] r;
    r = '0;
    case (tc)
      4'd1: casez (b)
        5'b1_????: r = e(1,0);  5'b010_??: r = e(3,1);  5'b011_??: r = e(3,2);
        5'b0010_?: r = e(4,3);  5'b0011_?: r = e(4,4);  5'b0001_?: r = e(4,5);
        5'b00001:  r = e(5,6);  5'b00000:  r = e(5,7);
        default: ;
      endcase
      4'd2: casez (b)
        5'b000_??: r = e(3,0);  5'b01_???: r = e(2,1);  5'b001_??: r = e(3,2);
        5'b100_??: r = e(3,3);  5'b101_??: r = e(3,4);  5'b110_??: r = e(3,5);
        5'b111_??: r = e(3,6);
        default: ;
      endcase
      4'd3: casez (b)
        5'b000_??: r = e(3,0);  5'b001_??: r = e(3,1);  5'b01_???: r = e(2,2);
        5'b10_???: r = e(2,3);  5'b110_??: r = e(3,4);  5'b111_??: r = e(3,5);
        default: ;
      endcase
      4'd4: casez (b)
        5'b110_??: r = e(3,0);  5'b00_???: r = e(2,1);  5'b01_???: r = e(2,2);
        5'b10_???: r = e(2,3);  5'b111_??: r = e(3,4);
        default: ;
      endcase
      4'd5: casez (b)
        5'b00_???: r = e(2,0);  5'b01_???: r = e(2,1);
        5'b10_???: r = e(2,2);  5'b11_???: r = e(2,3);
        default: ;
      endcase
      4'd6: casez (b)
        5'b00_???: r = e(2,0);  5'b01_???: r = e(2,1);  5'b1_????: r = e(1,2);
        default: ;
      endcase
      4'd7: casez (b)
        5'b0_????: r = e(1,0);  5'b1_????: r = e(1,1);
        default: ;
      endcase
      default: ;
    endcase
    return r;
  endfunction

  // run_before, row selected by min(zerosLeft, 7); all-zero 11-bit prefix is the only unmatched code
  function automatic logic [8:0] run_before(input logic [3:0] zl, input logic [10:0] b);
    logic [8:0] r;
    r = '0;
    case (zl)
      4'd1: r = b[10] ? e(1,0) : e(1,1);
      4'd2: casez (b[10:8])
        3'b1??: r = e(1,0);  3'b01?: r = e(2,1);  3'b00?: r = e(2,2);
        default: ;
      endcase
      4'd3: r = e(2, 3 - int'(b[10:9]));
      4'd4: casez (b[10:8])
        3'b11?: r = e(2,0);  3'b10?: r = e(2,1);  3'b01?: r = e(2,2);
        3'b001: r = e(3,3);  3'b000: r = e(3,4);
        default: ;
      endcase
      4'd5: casez (b[10:8])
        3'b11?: r = e(2,0);  3'b10?: r = e(2,1);  3'b011: r = e(3,2);
        3'b010: r = e(3,3);  3'b001: r = e(3,4);  3'b000: r = e(3,5);
        default: ;
      endcase
      4'd6: casez (b[10:8])
        3'b11?: r = e(2,0);  3'b000: r = e(3,1);  3'b001: r = e(3,2);
        3'b011: r = e(3,3);  3'b010: r = e(3,4);  3'b101: r = e(3,5);
        3'b100: r = e(3,6);
        default: ;
      endcase
      default: casez (b)
        11'b111_????????: r = e(3,0);   11'b110_????????: r = e(3,1);
        11'b101_????????: r = e(3,2);   11'b100_????????: r = e(3,3);
        11'b011_????????: r = e(3,4);   11'b010_????????: r = e(3,5);
        11'b001_????????: r = e(3,6);   11'b0001_???????: r = e(4,7);
        11'b00001_??????: r = e(5,8);   11'b000001_?????: r = e(6,9);
        11'b0000001_????: r = e(7,10);  11'b00000001_???: r = e(8,11);
        11'b000000001_??: r = e(9,12);  11'b0000000001_?: r = e(10,13);
        11'b00000000001:  r = e(11,14);
        default: ;
      endcase
    endcase
    return r;
  endfunction

  assign max_in = max_coeff(Mode);
  assign max_q  = max_coeff(mode_q);
  assign rb_w   = run_before(zl_q, win11);

  always_comb begin
    case (mode_q)
      2'd2:    tz_w = tz_c420(tc_q[3:0], win11[10:8]);
      2'd3:    tz_w = tz_c422(tc_q[3:0], win11[10:6]);
      default: tz_w = tz_luma(tc_q[3:0], win11[10:2]);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    tc_d      = tc_q;
    idx_d     = idx_q;
    zl_d      = zl_q;
    error_d   = error_q;
    NumShift  = 5'd0;
    ShiftEn   = 1'b0;
    RunValid  = 1'b0;
    RunIdx    = 4'd0;
    RunBefore = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (Enable) begin
          mode_d  = Mode;
          tc_d    = TotalCoeff;
          idx_d   = 4'd0;
          zl_d    = 4'd0;
          error_d = 1'b0;
          if (((Mode == 2'd3) && (CHROMA422_EN == 0)) || (TotalCoeff > max_in)) begin
            error_d = 1'b1;
            state_d = S_DONE;
          end else if (TotalCoeff == 5'd0) begin
            state_d = S_DONE;
          end else if (TotalCoeff == max_in) begin
            state_d = S_ZERO_RUN;
          end else begin
            state_d = S_TOTAL_ZERO;
          end
        end
      end
      S_TOTAL_ZERO: begin
        if (!tz_w[8] || ({1'b0, tz_w[3:0]} > (max_q - tc_q))) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          ShiftEn  = 1'b1;
          NumShift = {1'b0, tz_w[7:4]};
          zl_d     = tz_w[3:0];
          state_d  = S_ZERO_RUN;
        end
      end
      S_ZERO_RUN: begin
        RunIdx = idx_q;
        if ({1'b0, idx_q} == (tc_q - 5'd1)) begin
          RunValid  = 1'b1;
          RunBefore = zl_q;
          state_d   = S_DONE;
        end else if (zl_q == 4'd0) begin
          RunValid = 1'b1;
          idx_d    = idx_q + 4'd1;
        end else if (!rb_w[8] || (rb_w[3:0] > zl_q)) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          RunValid  = 1'b1;
          ShiftEn   = 1'b1;
          NumShift  = {1'b0, rb_w[7:4]};
          RunBefore = rb_w[3:0];
          zl_d      = zl_q - rb_w[3:0];
          idx_d     = idx_q + 4'd1;
        end
      end
      S_DONE: state_d = S_WAIT;
      S_WAIT: if (!Enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      tc_q    <= 5'd0;
      idx_q   <= 4'd0;
      zl_q    <= 4'd0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tc_q    <= tc_d;
      idx_q   <= idx_d;
      zl_q    <= zl_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign Done  = done_q;
  assign Error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_zero_run_decode.sv
`default_nettype none
// Bench for zero_run_decode: a table of blocks driven through a bit-accurate shifter
// model, with expected runs queued at stimulus time and compared as RunValid appears.
module tb_zero_run_decode;

  logic        Clk = 1'b0;
  logic        Reset, Enable, pos_clr;
  logic [1:0]  Mode;
  logic [4:0]  TotalCoeff;
  logic [63:0] bits, shifted;
  logic [15:0] win;
  int          pos = 0;

  logic [4:0] NumShift;
  logic       ShiftEn, RunValid, Done, Error;
  logic [3:0] RunIdx, RunBefore;

  logic [4:0] n2_NumShift;
  logic       n2_ShiftEn, n2_RunValid, n2_Done, n2_Error;
  logic [3:0] n2_RunIdx, n2_RunBefore;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [4:0]  tc;
    logic [63:0] bits;
    int          nruns;
    logic [63:0] runs;    // nibble i = expected RunBefore at RunIdx i
    int          nbits;
    int          done_c;
    logic        err;
  } vec_t;

  vec_t       vecs[13];
  logic [7:0] exp_q[$];

  zero_run_decode #(.CHROMA422_EN(1), .WIN_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Mode(Mode), .TotalCoeff(TotalCoeff),
    .BitstreamShifted(win), .NumShift(NumShift), .ShiftEn(ShiftEn), .RunValid(RunValid),
    .RunIdx(RunIdx), .RunBefore(RunBefore), .Done(Done), .Error(Error)
  );

  zero_run_decode #(.CHROMA422_EN(0), .WIN_W(16)) dut_no422 (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Mode(Mode), .TotalCoeff(TotalCoeff),
    .BitstreamShifted(win), .NumShift(n2_NumShift), .ShiftEn(n2_ShiftEn),
    .RunValid(n2_RunValid), .RunIdx(n2_RunIdx), .RunBefore(n2_RunBefore),
    .Done(n2_Done), .Error(n2_Error)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    shifted = bits << pos;
    win     = shifted[63:48];
  end

  always @(posedge Clk) begin
    if (pos_clr)      pos <= 0;
    else if (ShiftEn) pos <= pos + int'(NumShift);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_numshift"}, int'(NumShift), 0);
    chk({tag, "_shiften"}, int'(ShiftEn), 0);
    chk({tag, "_runvalid"}, int'(RunValid), 0);
    chk({tag, "_runidx"}, int'(RunIdx), 0);
    chk({tag, "_runbefore"}, int'(RunBefore), 0);
    chk({tag, "_done"}, int'(Done), 0);
    chk({tag, "_error"}, int'(Error), 0);
  endtask

  function automatic vec_t mkv(input int mode, input int tc, input logic [63:0] b,
                               input int nruns, input logic [63:0] runs,
                               input int nbits, input int done_c, input int err);
    vec_t v;
    v.mode = 2'(mode); v.tc = 5'(tc); v.bits = b; v.nruns = nruns; v.runs = runs;
    v.nbits = nbits; v.done_c = done_c; v.err = 1'(err);
    return v;
  endfunction

  // abort_c > 0 pulses Reset in that cycle of the block instead of waiting for Done
  task automatic run_block(input int vi, input int abort_c);
    vec_t       v;
    int         c;
    bit         seen_done;
    logic [7:0] ex;
    v = vecs[vi];
    @(negedge Clk); bits = v.bits; pos_clr = 1'b1;
    @(negedge Clk); pos_clr = 1'b0;
    exp_q.delete();
    for (int i = 0; i < v.nruns; i++) exp_q.push_back({4'(i), v.runs[4*i +: 4]});
    Mode = v.mode; TotalCoeff = v.tc; Enable = 1'b1;
    c = 1; seen_done = 1'b0;
    while (!seen_done && c < 40) begin
      @(posedge Clk); @(negedge Clk); c++;
      if (!ShiftEn) chk($sformatf("v%0d_numshift_idle", vi), int'(NumShift), 0);
      else          chk($sformatf("v%0d_numshift_max", vi), int'(NumShift <= 5'd11), 1);
      if (RunValid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL v%0d_extra_run: actual idx=%0d run=%0d required none", vi, RunIdx, RunBefore);
        end else begin
          ex = exp_q.pop_front();
          chk($sformatf("v%0d_runidx", vi), int'(RunIdx), int'(ex[7:4]));
          chk($sformatf("v%0d_run%0d", vi, ex[7:4]), int'(RunBefore), int'(ex[3:0]));
        end
      end
      if (abort_c > 0 && c == abort_c) begin
        Reset = 1'b1; Enable = 1'b0;
        @(posedge Clk); @(negedge Clk);
        chk_outputs_zero("abort");
        Reset = 1'b0;
        repeat (4) begin
          @(posedge Clk); @(negedge Clk);
          chk("abort_no_done", int'(Done), 0);
        end
        exp_q.delete();
        return;
      end
      if (Done) seen_done = 1'b1;
    end
    if (!seen_done) begin
      checks++; errors++;
      $display("FAIL v%0d_timeout: actual no Done after %0d cycles required Done", vi, c);
    end else begin
      chk($sformatf("v%0d_done_cycle", vi), c, v.done_c);
      chk($sformatf("v%0d_error", vi), int'(Error), int'(v.err));
      chk($sformatf("v%0d_bits_used", vi), pos, v.nbits);
      chk($sformatf("v%0d_runs_left", vi), exp_q.size(), 0);
    end
    repeat (3) begin
      @(posedge Clk); @(negedge Clk);
      chk($sformatf("v%0d_no_second_done", vi), int'(Done), 0);
    end
    Enable = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    vecs[0]  = mkv(0, 5,  {8'b11110100, 56'd0},        5,  64'h201, 8, 8,  0);
    vecs[1]  = mkv(2, 1,  {3'b001, 61'd0},             1,  64'h2,   3, 4,  0);
    vecs[2]  = mkv(0, 16, {64{1'b1}},                  16, 64'h0,   0, 18, 0);
    vecs[3]  = mkv(0, 0,  {64{1'b1}},                  0,  64'h0,   0, 2,  0);
    vecs[4]  = mkv(2, 5,  {64{1'b1}},                  0,  64'h0,   0, 2,  1);
    vecs[5]  = mkv(0, 2,  {4'b0010, 60'd0},            0,  64'h0,   4, 4,  1);
    vecs[6]  = mkv(3, 2,  {5'b10001, 59'd0},           2,  64'h12,  5, 5,  0);
    vecs[7]  = mkv(1, 1,  {9'b000000001, 55'd0},       0,  64'h0,   0, 3,  1);
    vecs[8]  = mkv(1, 15, {64{1'b1}},                  15, 64'h0,   0, 17, 0);
    vecs[9]  = mkv(0, 3,  {9'b011100001, 55'd0},       3,  64'h133, 9, 6,  0);
    vecs[10] = mkv(0, 2,  {9'b0011_00001, 55'd0},      0,  64'h0,   4, 4,  1);
    vecs[11] = mkv(0, 1,  64'd0,                       0,  64'h0,   0, 3,  1);
    vecs[12] = mkv(2, 3,  {1'b1, 63'd0},               3,  64'h0,   1, 6,  0);

    Reset = 1'b1; Enable = 1'b0; Mode = 2'd0; TotalCoeff = 5'd0;
    bits = 64'd0; pos_clr = 1'b1;
    repeat (2) @(negedge Clk);
    chk_outputs_zero("reset");
    Reset = 1'b0;

    for (int i = 0; i < 13; i++) run_block(i, 0);

    // chroma 4:2:2 disabled: immediate error and Done, nothing consumed
    @(negedge Clk); bits = {5'b10001, 59'd0}; pos_clr = 1'b1;
    @(negedge Clk); pos_clr = 1'b0; Mode = 2'd3; TotalCoeff = 5'd2; Enable = 1'b1;
    @(posedge Clk); @(negedge Clk);
    chk("no422_done", int'(n2_Done), 1);
    chk("no422_error", int'(n2_Error), 1);
    chk("no422_shiften", int'(n2_ShiftEn), 0);
    repeat (6) @(negedge Clk);
    Enable = 1'b0;
    repeat (2) @(negedge Clk);

    // reset in the third ZERO_RUN cycle, then the same block again from scratch
    run_block(0, 5);
    run_block(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
